alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters, e.g. the instruction datapath (port 0) and a debug/DMA agent (port 1).
- Each requester has a valid/ready command channel and a valid/ready response channel.
- A round-robin FSM grants one command at a time and drives the ALU operand/select inputs from registers.
- It waits a fixed settle interval, captures RESULT/ZERO, and returns them to the granted requester.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the ALU.
SETTLE_CYCLES, 2, clock cycles the ALU inputs are held before RESULT is sampled; legal range 1..15.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
REQ_VALID  input  2  per-requester command valid; bit i = requester i.
REQ_READY  output  2  per-requester command ready.
REQ_OP  input  6  3-bit opcode per requester; requester i uses bits [3i+2:3i].
REQ_A  input  16  DATA1 operand per requester; requester i uses bits [8i+7:8i].
REQ_B  input  16  DATA2 operand per requester; same packing as REQ_A.
RSP_VALID  output  2  per-requester response valid.
RSP_READY  input  2  per-requester response ready.
RSP_RESULT  output  8  captured ALU result; shared by both ports, qualified by RSP_VALID.
RSP_ZERO  output  1  zero flag; shared by both ports.
RSP_ERR  output  1  illegal-opcode flag; shared by both ports.
ALU_DATA1  output  8  to ALU DATA1.
ALU_DATA2  output  8  to ALU DATA2.
ALU_SELECT  output  3  to ALU SELECT.
ALU_RESULT  input  8  from ALU RESULT.
ALU_ZERO  input  1  from ALU ZERO.

Behaviour:
- Opcodes: 000 FORWARD (result = B), 001 ADD, 010 AND, 011 OR. Opcodes 1xx are illegal.
- FSM states: IDLE, WAIT, RESP.
- Reset (any state, including mid-operation):
  - state = IDLE; in-flight command dropped.
  - REQ_READY=00, RSP_VALID=00.
  - RSP_RESULT/RSP_ZERO/RSP_ERR = 0.
  - ALU_DATA1/ALU_DATA2 = 0, ALU_SELECT = 000.
  - Wait counter = 0; last-grant pointer = 1, so requester 0 wins first.
- Grant (IDLE only, combinational):
  - Exactly one of REQ_VALID set -> grant it.
  - Both set -> grant the requester other than the last granted.
  - REQ_READY[g] = 1 only for the granted requester, only in IDLE; REQ_READY = 00 in WAIT and RESP.
- Accept edge (IDLE, REQ_VALID[g] & REQ_READY[g]):
  - Latch g.
  - Legal op: load ALU_DATA1/ALU_DATA2/ALU_SELECT from the requester's fields; counter = SETTLE_CYCLES-1; go to WAIT.
  - Illegal op: ALU outputs unchanged; RSP_RESULT=0, RSP_ZERO=0, RSP_ERR=1; go to RESP.
- WAIT:
  - ALU outputs held stable.
  - Counter decrements each cycle.
  - On the edge where counter==0: capture ALU_RESULT into RSP_RESULT; RSP_ERR=0; go to RESP.
  - RSP_ZERO = ALU_ZERO if op==ADD, else 0. The ALU updates ZERO only on ADD; do not forward a stale flag.
- Latency: legal op accepted at edge E0 -> RSP_VALID[g] high after edge E(SETTLE_CYCLES). Illegal op -> RSP_VALID high after E0.
- RESP:
  - RSP_VALID[g]=1, other bit 0; RSP_* held stable until handshake.
  - Handshake edge (RSP_VALID[g] & RSP_READY[g]): RSP_VALID clears, last-grant = g, go to IDLE.
  - No new accept in the handshake cycle. Max throughput: one legal op per SETTLE_CYCLES+2 cycles.
- Requests are not dropped: REQ_VALID may stay high indefinitely; the requester must hold its fields stable while REQ_VALID=1 and not ready.
- RSP_READY of the non-granted port is ignored.
- Arithmetic: ADD wraps modulo 256; no carry output.

Decomposition:
- Shared package alu_pkg: opcode constants OP_FWD=3'b000, OP_ADD=3'b001, OP_AND=3'b010, OP_OR=3'b011; state encoding IDLE/WAIT/RESP; DATA_WIDTH default.
- One natural sub-module, rr_arbiter2: a 2-way round-robin grant from valid bits plus last-grant pointer, combinational.
- FSM, counter and capture registers stay in alu_arbiter.

Test Plan:
1. Reset mid-WAIT (RESET high 1 cycle) -> next cycle state IDLE, RSP_VALID=00, ALU_SELECT=000, ALU_DATA1/2=0; stale response never appears.
2. Port 0 ADD A=8'h05 B=8'h03, RSP_READY=1 -> RSP_VALID[0] high after 2 cycles (default), RSP_RESULT=8'h08, RSP_ZERO=0, RSP_ERR=0.
3. Port 1 ADD A=8'hFF B=8'h01 -> RSP_RESULT=8'h00, RSP_ZERO=1. Then port 1 OR A=8'h00 B=8'h00 -> RSP_RESULT=0, RSP_ZERO=0.
4. Both ports valid continuously (port 0 AND A=8'hF0 B=8'h3C; port 1 FWD B=8'h5A) -> grants alternate 0,1,0,1; results 8'h30 and 8'h5A; no starvation over 10 ops.
5. Port 0 op=3'b110 -> RSP_VALID[0] after 1 cycle, RSP_ERR=1, RSP_RESULT=0; ALU_SELECT/ALU_DATA unchanged from previous op.
6. Response backpressure: RSP_READY[0]=0 for 5 cycles with port 1 REQ_VALID=1 -> REQ_READY=00 throughout, RSP fields stable; port 1 granted the cycle after the port 0 handshake.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding and opcode legality.
package alu_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // The ALU implements only the 0xx opcodes; anything with the top bit set is rejected.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last time.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Grant decode from the valid pair and the last-grant pointer
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        case (valid)
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_idx   = ~last_grant;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters: grants a command,
// holds the ALU inputs for a settle interval, then returns the captured result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [1:0]              REQ_VALID,
    output logic [1:0]              REQ_READY,
    input  logic [5:0]              REQ_OP,
    input  logic [2*DATA_WIDTH-1:0] REQ_A,
    input  logic [2*DATA_WIDTH-1:0] REQ_B,
    output logic [1:0]              RSP_VALID,
    input  logic [1:0]              RSP_READY,
    output logic [DATA_WIDTH-1:0]   RSP_RESULT,
    output logic                    RSP_ZERO,
    output logic                    RSP_ERR,
    output logic [DATA_WIDTH-1:0]   ALU_DATA1,
    output logic [DATA_WIDTH-1:0]   ALU_DATA2,
    output logic [2:0]              ALU_SELECT,
    input  logic [DATA_WIDTH-1:0]   ALU_RESULT,
    input  logic                    ALU_ZERO
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t                  state_r, state_s;
    logic [3:0]              cnt_r, cnt_s;
    logic                    last_r, last_s;
    logic                    gnt_r, gnt_s;
    logic [1:0]              rsp_valid_r, rsp_valid_s;
    logic [DATA_WIDTH-1:0]   result_r, result_s;
    logic                    zero_r, zero_s;
    logic                    err_r, err_s;
    logic [DATA_WIDTH-1:0]   d1_r, d1_s;
    logic [DATA_WIDTH-1:0]   d2_r, d2_s;
    logic [2:0]              sel_r, sel_s;

    logic                    arb_valid_s;
    logic                    arb_idx_s;
    logic [1:0]              req_ready_s;
    logic [2:0]              req_op_s;
    logic [DATA_WIDTH-1:0]   req_a_s;
    logic [DATA_WIDTH-1:0]   req_b_s;

    rr_arbiter2 u_rr (
        .valid       (REQ_VALID),
        .last_grant  (last_r),
        .grant_valid (arb_valid_s),
        .grant_idx   (arb_idx_s)
    );

    assign req_op_s = arb_idx_s ? REQ_OP[5:3] : REQ_OP[2:0];
    assign req_a_s  = arb_idx_s ? REQ_A[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_A[DATA_WIDTH-1:0];
    assign req_b_s  = arb_idx_s ? REQ_B[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_B[DATA_WIDTH-1:0];

    // Ready is offered only to the current grant and only while idle
    always_comb begin
        req_ready_s = 2'b00;
        if ((state_r == IDLE) && arb_valid_s) begin
            req_ready_s = arb_idx_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Next-state and next-register values for the grant/settle/respond sequence
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        last_s      = last_r;
        gnt_s       = gnt_r;
        rsp_valid_s = rsp_valid_r;
        result_s    = result_r;
        zero_s      = zero_r;
        err_s       = err_r;
        d1_s        = d1_r;
        d2_s        = d2_r;
        sel_s       = sel_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    gnt_s = arb_idx_s;
                    if (op_is_legal(req_op_s)) begin
                        d1_s    = req_a_s;
                        d2_s    = req_b_s;
                        sel_s   = req_op_s;
                        cnt_s   = SETTLE_INIT;
                        state_s = WAIT;
                    end else begin
                        // Rejected opcodes never touch the ALU inputs
                        result_s    = '0;
                        zero_s      = 1'b0;
                        err_s       = 1'b1;
                        rsp_valid_s = arb_idx_s ? 2'b10 : 2'b01;
                        state_s     = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    result_s    = ALU_RESULT;
                    // ALU only refreshes ZERO on ADD, so any other op reports a clear flag
                    zero_s      = (sel_r == OP_ADD) ? ALU_ZERO : 1'b0;
                    err_s       = 1'b0;
                    rsp_valid_s = gnt_r ? 2'b10 : 2'b01;
                    state_s     = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (RSP_READY[gnt_r]) begin
                    rsp_valid_s = 2'b00;
                    last_s      = gnt_r;
                    state_s     = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                rsp_valid_s = 2'b00;
                state_s     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            last_r      <= 1'b1;
            gnt_r       <= 1'b0;
            rsp_valid_r <= 2'b00;
            result_r    <= '0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
            d1_r        <= '0;
            d2_r        <= '0;
            sel_r       <= 3'b000;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            last_r      <= last_s;
            gnt_r       <= gnt_s;
            rsp_valid_r <= rsp_valid_s;
            result_r    <= result_s;
            zero_r      <= zero_s;
            err_r       <= err_s;
            d1_r        <= d1_s;
            d2_r        <= d2_s;
            sel_r       <= sel_s;
        end
    end

    assign REQ_READY  = req_ready_s;
    assign RSP_VALID  = rsp_valid_r;
    assign RSP_RESULT = result_r;
    assign RSP_ZERO   = zero_r;
    assign RSP_ERR    = err_r;
    assign ALU_DATA1  = d1_r;
    assign ALU_DATA2  = d2_r;
    assign ALU_SELECT = sel_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model predicts every output each cycle,
// and directed scenarios pin hand-computed results, latencies and grant order.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int SETTLE = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  REQ_VALID;
    logic [1:0]  REQ_READY;
    logic [5:0]  REQ_OP;
    logic [15:0] REQ_A;
    logic [15:0] REQ_B;
    logic [1:0]  RSP_VALID;
    logic [1:0]  RSP_READY;
    logic [7:0]  RSP_RESULT;
    logic        RSP_ZERO;
    logic        RSP_ERR;
    logic [7:0]  ALU_DATA1;
    logic [7:0]  ALU_DATA2;
    logic [2:0]  ALU_SELECT;
    logic [7:0]  ALU_RESULT;
    logic        ALU_ZERO;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 CLK = ~CLK;

    alu_arbiter #(.DATA_WIDTH(8), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_OP     (REQ_OP),
        .REQ_A      (REQ_A),
        .REQ_B      (REQ_B),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_RESULT (RSP_RESULT),
        .RSP_ZERO   (RSP_ZERO),
        .RSP_ERR    (RSP_ERR),
        .ALU_DATA1  (ALU_DATA1),
        .ALU_DATA2  (ALU_DATA2),
        .ALU_SELECT (ALU_SELECT),
        .ALU_RESULT (ALU_RESULT),
        .ALU_ZERO   (ALU_ZERO)
    );

    function automatic logic [7:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return b;
            3'b001:  return 8'(a + b);
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 8'h00;
        endcase
    endfunction

    // External ALU; ZERO is deliberately garbage (1) on anything but ADD
    always_comb begin
        case (ALU_SELECT)
            3'b000:  ALU_RESULT = ALU_DATA2;
            3'b001:  ALU_RESULT = 8'(ALU_DATA1 + ALU_DATA2);
            3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
            3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
            default: ALU_RESULT = 8'hA5;
        endcase
        ALU_ZERO = (ALU_SELECT == 3'b001) ? (8'(ALU_DATA1 + ALU_DATA2) == 8'h00) : 1'b1;
    end

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 1 : 0;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 settling, 2 responding
    int         m_phase, m_left, m_port, m_last, m_g;
    logic [7:0] m_res, m_d1, m_d2, m_a, m_b, m_r;
    logic [2:0] m_sel, m_op;
    logic       m_zero, m_err;
    logic [1:0] exp_rdy, exp_vld;

    always_comb begin
        m_g     = pick(REQ_VALID, m_last);
        m_op    = (m_g == 1) ? REQ_OP[5:3] : REQ_OP[2:0];
        m_a     = (m_g == 1) ? REQ_A[15:8] : REQ_A[7:0];
        m_b     = (m_g == 1) ? REQ_B[15:8] : REQ_B[7:0];
        m_r     = alu_calc(m_sel, m_d1, m_d2);
        exp_rdy = (m_phase == 0 && m_g >= 0) ? ((m_g == 0) ? 2'b01 : 2'b10) : 2'b00;
        exp_vld = (m_phase == 2) ? ((m_port == 0) ? 2'b01 : 2'b10) : 2'b00;
    end

    always @(posedge CLK) begin
        if (RESET) begin
            m_phase <= 0; m_left <= 0; m_port <= 0; m_last <= 1;
            m_res <= 8'h00; m_zero <= 1'b0; m_err <= 1'b0;
            m_d1 <= 8'h00; m_d2 <= 8'h00; m_sel <= 3'b000;
        end else begin
            case (m_phase)
                0: if (m_g >= 0) begin
                    m_port <= m_g;
                    if (m_op > 3'd3) begin
                        m_res <= 8'h00; m_zero <= 1'b0; m_err <= 1'b1; m_phase <= 2;
                    end else begin
                        m_d1 <= m_a; m_d2 <= m_b; m_sel <= m_op; m_left <= SETTLE; m_phase <= 1;
                    end
                end
                1: if (m_left == 1) begin
                    m_res   <= m_r;
                    m_zero  <= (m_sel == 3'b001) && (m_r == 8'h00);
                    m_err   <= 1'b0;
                    m_phase <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                2: if (RSP_READY[m_port]) begin
                    m_phase <= 0;
                    m_last  <= m_port;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("req_ready",  32'(REQ_READY),  32'(exp_rdy));
            chk("rsp_valid",  32'(RSP_VALID),  32'(exp_vld));
            chk("rsp_result", 32'(RSP_RESULT), 32'(m_res));
            chk("rsp_zero",   32'(RSP_ZERO),   32'(m_zero));
            chk("rsp_err",    32'(RSP_ERR),    32'(m_err));
            chk("alu_data1",  32'(ALU_DATA1),  32'(m_d1));
            chk("alu_data2",  32'(ALU_DATA2),  32'(m_d2));
            chk("alu_select", 32'(ALU_SELECT), 32'(m_sel));
        end
    end

    task automatic issue(input int p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bit got;
        got = 1'b0;
        REQ_OP[3*p +: 3] = op;
        REQ_A[8*p +: 8]  = a;
        REQ_B[8*p +: 8]  = b;
        REQ_VALID[p]     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (REQ_READY[p]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout port %0d: got no REQ_READY, expected one within 50 cycles", p);
        end
        @(posedge CLK); #1;
        REQ_VALID[p] = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int p, input int lat,
                              input logic [7:0] res, input logic z, input logic e);
        bit got;
        int k;
        got = 1'b0;
        k   = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (RSP_VALID[p]) begin
                got = 1'b1;
                break;
            end
            k++;
        end
        chk({tag, "_seen"},    32'(got),        32'd1);
        chk({tag, "_latency"}, 32'(k),          32'(lat));
        chk({tag, "_result"},  32'(RSP_RESULT), 32'(res));
        chk({tag, "_zero"},    32'(RSP_ZERO),   32'(z));
        chk({tag, "_err"},     32'(RSP_ERR),    32'(e));
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ngr;
        RESET = 1'b1; REQ_VALID = 2'b00; REQ_OP = 6'd0; REQ_A = 16'd0; REQ_B = 16'd0; RSP_READY = 2'b00;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        chk_en = 1'b1;
        @(negedge CLK);
        chk("reset_req_ready", 32'(REQ_READY), 32'd0);
        chk("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("reset_result",    32'(RSP_RESULT), 32'd0);
        chk("reset_sel",       32'(ALU_SELECT), 32'd0);
        @(posedge CLK); #1;

        // Reset while settling drops the command
        issue(0, OP_ADD, 8'h77, 8'h11);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("midwait_rsp_valid", 32'(RSP_VALID),  32'd0);
        chk("midwait_sel",       32'(ALU_SELECT), 32'd0);
        chk("midwait_d1",        32'(ALU_DATA1),  32'd0);
        chk("midwait_d2",        32'(ALU_DATA2),  32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("midwait_no_stale", 32'(RSP_VALID), 32'd0);
        end
        @(posedge CLK); #1;

        RSP_READY = 2'b11;
        issue(0, OP_ADD, 8'h05, 8'h03);
        expect_rsp("t2_add", 0, SETTLE, 8'h08, 1'b0, 1'b0);
        issue(1, OP_ADD, 8'hFF, 8'h01);
        expect_rsp("t3_wrap", 1, SETTLE, 8'h00, 1'b1, 1'b0);
        issue(1, OP_OR, 8'h00, 8'h00);
        expect_rsp("t3_or", 1, SETTLE, 8'h00, 1'b0, 1'b0);

        // Both requesters continuously valid: grants must alternate from port 0
        REQ_OP[2:0] = OP_AND; REQ_A[7:0]  = 8'hF0; REQ_B[7:0]  = 8'h3C;
        REQ_OP[5:3] = OP_FWD; REQ_A[15:8] = 8'h11; REQ_B[15:8] = 8'h5A;
        REQ_VALID = 2'b11;
        ngr = 0;
        for (int i = 0; i < 200 && ngr < 10; i++) begin
            @(negedge CLK);
            if (RSP_VALID == 2'b01) chk("t4_res0", 32'(RSP_RESULT), 32'h30);
            if (RSP_VALID == 2'b10) chk("t4_res1", 32'(RSP_RESULT), 32'h5A);
            if (REQ_READY != 2'b00) begin
                chk("t4_grant", 32'(REQ_READY), (ngr % 2 == 0) ? 32'h1 : 32'h2);
                ngr++;
            end
        end
        chk("t4_grant_count", 32'(ngr), 32'd10);
        @(posedge CLK); #1;
        REQ_VALID = 2'b00;
        repeat (SETTLE + 3) @(posedge CLK);
        #1;

        issue(0, 3'b110, 8'hEE, 8'hDD);
        expect_rsp("t5_illegal", 0, 0, 8'h00, 1'b0, 1'b1);
        chk("t5_sel_kept", 32'(ALU_SELECT), 32'h0);
        chk("t5_d1_kept",  32'(ALU_DATA1),  32'h11);
        chk("t5_d2_kept",  32'(ALU_DATA2),  32'h5A);

        // Backpressure on port 0 while port 1 waits; port 1's ready must be ignored
        RSP_READY = 2'b10;
        issue(0, OP_ADD, 8'h10, 8'h20);
        REQ_OP[5:3] = OP_OR; REQ_A[15:8] = 8'h0F; REQ_B[15:8] = 8'hF0;
        REQ_VALID[1] = 1'b1;
        expect_rsp("t6_held", 0, SETTLE, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t6_req_ready", 32'(REQ_READY),  32'd0);
            chk("t6_rsp_valid", 32'(RSP_VALID),  32'h1);
            chk("t6_result",    32'(RSP_RESULT), 32'h30);
        end
        @(posedge CLK); #1;
        RSP_READY = 2'b11;
        @(posedge CLK);
        @(negedge CLK);
        chk("t6_port1_grant", 32'(REQ_READY), 32'h2);
        @(posedge CLK); #1;
        REQ_VALID[1] = 1'b0;
        expect_rsp("t6_port1", 1, SETTLE, 8'hFF, 1'b0, 1'b0);

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
